global_cfg_dispatcher: RTL and testbench
========================================

Name: global_cfg_dispatcher

Overview:
Successor to the global vl/vtype tracker in the VLSU. It snoops CVA6 accelerator requests and decodes vsetvl/vsetvli/vsetivli. It keeps the architectural vl/vtype, splits vl element-interleaved across NrClusters, and broadcasts each new configuration to every cluster through a CfgDepth-deep FIFO with independent per-cluster valid/ready handshakes. It can backpressure the front end.

Parameters:
NrClusters, 4, number of clusters; power of two, ≥1
CfgDepth, 2, configuration FIFO entries; ≥1
vlen_cl_t, logic, type of the global vl (must hold VLMAX across all clusters)
vlen_t, logic, type of the per-cluster vl

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
acc_req_i  in  accelerator_req_t  CVA6 request (req_valid, insn, rs1, rs2)
acc_ready_o  out  1  dispatcher can accept a request
vl_o  out  $bits(vlen_cl_t)  architectural global vl
vtype_o  out  vtype_t  architectural vtype
cl_cfg_valid_o  out  NrClusters  per-cluster config valid
cl_cfg_ready_i  in  NrClusters  per-cluster config accept
cl_vl_o  out  NrClusters x $bits(vlen_t)  per-cluster vl of the FIFO head
cl_vtype_o  out  vtype_t  vtype of the FIFO head, shared by all clusters

Behaviour:
- Clocking and reset: one clock, clk_i. Reset is synchronous, active-high on rst_i.
- Reset values: vl_o=0; vtype_o={vill:1, others 0}; FIFO empty; ack mask 0; cl_cfg_valid_o=0; cl_vl_o=0; cl_vtype_o={vill:1, others 0}; acc_ready_o=1 from the first cycle after reset.
- acc_ready_o = !fifo_full. There is no bypass: a pop in the same cycle does not free a slot for a push.
- Acceptance: a request is accepted when req_valid && acc_ready_o.
  - Non-OPCFG requests are accepted and ignored.
  - Accepted vset* requests update vl/vtype (visible on vl_o/vtype_o next cycle) and push {vl, vtype} in the same cycle.
- vtype decode:
  - vsetvli: zimm11. vsetivli (func2=11): zimm10. vsetvl (func7=1000000): rs2[7:0].
  - vill is set, and vl=0, if any of: vsew > clog2(ELENB); vlmul == LMUL_RSVD; clog2(ELENB) + signed(vlmul) < vsew.
  - vill configurations are still pushed so clusters observe vill.
- vl computation:
  - VLMAX = ((VLENB << clog2(NrClusters)) >> vsew), then shifted by LMUL (left 0..3; right 1..3 for fractional).
  - vsetivli: vl = uimm5 (not clamped).
  - rs1=0, rd=0: vl unchanged.
  - rs1=0, rd≠0: vl = VLMAX.
  - Otherwise vl = min(rs1, VLMAX). Any set rs1 bit above the vl width forces VLMAX.
- Cluster split:
  - base = vl >> clog2(NrClusters); rem = vl & (NrClusters-1).
  - Cluster i gets base + (i < rem). Computed at push and stored per entry.
- Broadcast FSM:
  - IDLE: FIFO empty, all valids 0.
  - BCAST: head valid. cl_cfg_valid_o[i] = !ack[i]. A handshake on cluster i sets ack[i].
  - When ack | (valid & ready) is all-ones: pop the head, clear ack, move to the next entry (BCAST) or IDLE. The next head is presented the cycle after the pop, not combinationally.
  - Once ack[i] is set, a cluster never sees a duplicate valid for the same entry.
- Ordering: entries are delivered in acceptance order. Clusters may ack in any order and in any cycles.
- Full FIFO with a valid vset request: request held off (acc_ready_o=0); architectural state unchanged.
- Reset mid-broadcast: FIFO and ack mask are flushed, partial delivery is discarded, and all outputs return to reset values.
- Wrap-around: read/write pointers use clog2(CfgDepth) bits plus a wrap bit. Full/empty are derived from the pointers.

Optional Feature:
GLOBAL_CFG_DISP_PERF_EN
- Defined: adds 32-bit counters, cleared by rst_i, that wrap on overflow:
  - vset_cnt_o: accepted vset* requests.
  - stall_cnt_o: cycles with req_valid && !acc_ready_o.
  - vill_cnt_o: accepted configs that resolved to vill.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Config used by all tests: NrClusters=4, VLENB=128, ELENB=8.
- vsetvli e8 m1, rs1=37 -> vl_o=37; cl_vl_o={10,9,9,9}; all four valids rise the cycle after acceptance.
- vsetvli e32 m2, rs1=x0, rd=x1 -> vl_o=256; cl_vl_o={64,64,64,64}.
- vsetvl with rs2 giving e64, LMUL 1/8 -> vtype_o.vill=1; vl_o=0; cl_vtype_o.vill=1; cl_vl_o all 0.
- vsetvli e8 m8, rs1=0x1_0000_0000 -> vl_o=4096 (VLMAX clamp).
- CfgDepth=2, cl_cfg_ready_i[2] held 0, three back-to-back vsets -> clusters 0,1,3 ack the head; cluster 2 valid stays 1; acc_ready_o=0 once two entries are queued and the third is held off. Release cluster 2 -> entries delivered in order; acc_ready_o returns to 1 the cycle after the pop.
- Assert rst_i mid-broadcast -> next cycle all valids 0, vl_o=0, vtype_o.vill=1, acc_ready_o=1.

Source files
------------

// File: rtl/global_cfg_dispatcher.sv
// Tracks architectural vl/vtype from snooped vset* requests and broadcasts each config to all clusters.
// Optional perf counters (vset_cnt_o, stall_cnt_o, vill_cnt_o) under `GLOBAL_CFG_DISP_PERF_EN.
module global_cfg_dispatcher #(
    parameter int unsigned NrClusters = 4,
    parameter int unsigned CfgDepth   = 2,
    parameter int unsigned VLENB      = 128,
    parameter int unsigned ELENB      = 8,
    parameter int unsigned XLEN       = 64,
    parameter type vlen_cl_t = logic [$clog2(VLENB*NrClusters*8+1)-1:0],
    parameter type vlen_t    = logic [$clog2(VLENB*8+1)-1:0]
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    // {req_valid, insn[31:0], rs1[XLEN-1:0], rs2[XLEN-1:0]}
    input  logic [2*XLEN+32:0]                  acc_req_i,
    output logic                                acc_ready_o,
    output logic [$bits(vlen_cl_t)-1:0]         vl_o,
    // {vill, vma, vta, vsew[2:0], vlmul[2:0]}
    output logic [8:0]                          vtype_o,
    output logic [NrClusters-1:0]               cl_cfg_valid_o,
    input  logic [NrClusters-1:0]               cl_cfg_ready_i,
    output logic [NrClusters*$bits(vlen_t)-1:0] cl_vl_o,
    output logic [8:0]                          cl_vtype_o
`ifdef GLOBAL_CFG_DISP_PERF_EN
    ,
    output logic [31:0]                         vset_cnt_o,
    output logic [31:0]                         stall_cnt_o,
    output logic [31:0]                         vill_cnt_o
`endif
);

    localparam int VlClW   = $bits(vlen_cl_t);
    localparam int VlW     = $bits(vlen_t);
    localparam int NcLog   = $clog2(NrClusters);
    localparam int ElenLog = $clog2(ELENB);
    localparam int AddrW   = (CfgDepth > 1) ? $clog2(CfgDepth) : 1;
    localparam logic [8:0] VtypeRst = 9'h100;

    typedef enum logic {IDLE, BCAST} state_e;

    logic             req_valid;
    logic [31:0]      insn;
    logic [XLEN-1:0]  rs1_val;
    logic [7:0]       rs2_vtype;
    logic             unused_req;

    assign req_valid  = acc_req_i[2*XLEN+32];
    assign insn       = acc_req_i[2*XLEN+31:2*XLEN];
    assign rs1_val    = acc_req_i[2*XLEN-1:XLEN];
    assign rs2_vtype  = acc_req_i[7:0];
    assign unused_req = ^{acc_req_i[XLEN-1:8], insn[30:28]};

    logic       is_opcfg, is_vsetvli, is_vsetivli, is_vsetvl, is_vset;
    logic [4:0] rd_idx, rs1_idx;

    assign is_opcfg    = (insn[6:0] == 7'h57) && (insn[14:12] == 3'b111);
    assign is_vsetvli  = is_opcfg && !insn[31];
    assign is_vsetivli = is_opcfg && (insn[31:30] == 2'b11);
    assign is_vsetvl   = is_opcfg && (insn[31:25] == 7'b1000000);
    assign is_vset     = is_vsetvli || is_vsetivli || is_vsetvl;
    assign rd_idx      = insn[11:7];
    assign rs1_idx     = insn[19:15];

    state_e                      state_q, state_d;
    logic [NrClusters-1:0]       ack_q, ack_d, hs;
    logic [AddrW:0]              wr_q, wr_d, rd_q, rd_d;
    logic [VlClW-1:0]            vl_q, vl_new, vlmax, base, rem;
    logic [8:0]                  vtype_q, vtype_new;
    logic [7:0]                  vtype_raw;
    logic [2:0]                  vsew, vlmul;
    logic                        new_vill, full, push;
    logic [NrClusters*VlW-1:0]   split;
    logic [NrClusters*VlW-1:0]   mem_vl_q    [CfgDepth];
    logic [8:0]                  mem_vtype_q [CfgDepth];

    // zimm10 and zimm11 share the same low byte position
    assign vtype_raw = is_vsetvl ? rs2_vtype : insn[27:20];
    assign vsew      = vtype_raw[5:3];
    assign vlmul     = vtype_raw[2:0];

    always_comb begin
        new_vill = (int'(vsew) > ElenLog) || (vlmul == 3'b100) ||
                   (ElenLog + int'($signed(vlmul)) < int'(vsew));
        vtype_new = new_vill ? VtypeRst : {1'b0, vtype_raw};

        vlmax = VlClW'((VLENB * NrClusters) >> vsew);
        if (!vlmul[2]) vlmax = vlmax << vlmul[1:0];
        else           vlmax = vlmax >> (3'd0 - vlmul);

        if (new_vill)
            vl_new = '0;
        else if (is_vsetivli)
            vl_new = VlClW'(rs1_idx);
        else if (rs1_idx == 5'd0 && rd_idx == 5'd0)
            vl_new = vl_q;
        else if (rs1_idx == 5'd0)
            vl_new = vlmax;
        else if ((|rs1_val[XLEN-1:VlClW]) || (rs1_val[VlClW-1:0] > vlmax))
            vl_new = vlmax;
        else
            vl_new = rs1_val[VlClW-1:0];

        base  = vl_new >> NcLog;
        rem   = vl_new & VlClW'(NrClusters - 1);
        split = '0;
        for (int i = 0; i < NrClusters; i++)
            split[i*VlW +: VlW] = VlW'(base) + VlW'(VlClW'(i) < rem);
    end

    function automatic logic [AddrW:0] ptr_inc(input logic [AddrW:0] p);
        logic [AddrW:0] r;
        r = p;
        if (p[AddrW-1:0] == AddrW'(CfgDepth - 1)) begin
            r[AddrW-1:0] = '0;
            r[AddrW]     = ~p[AddrW];
        end else begin
            r[AddrW-1:0] = p[AddrW-1:0] + 1'b1;
        end
        return r;
    endfunction

    assign full        = (wr_q[AddrW-1:0] == rd_q[AddrW-1:0]) && (wr_q[AddrW] != rd_q[AddrW]);
    assign acc_ready_o = !full;
    assign push        = req_valid && acc_ready_o && is_vset;

    assign cl_cfg_valid_o = (state_q == BCAST) ? ~ack_q : '0;
    assign hs             = cl_cfg_valid_o & cl_cfg_ready_i;
    assign cl_vl_o        = (state_q == BCAST) ? mem_vl_q[rd_q[AddrW-1:0]] : '0;
    assign cl_vtype_o     = (state_q == BCAST) ? mem_vtype_q[rd_q[AddrW-1:0]] : VtypeRst;
    assign vl_o           = vl_q;
    assign vtype_o        = vtype_q;

    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        unique case (state_q)
            IDLE: ack_d = '0;
            BCAST: begin
                if (&(ack_q | hs)) begin
                    ack_d = '0;
                    rd_d  = ptr_inc(rd_q);
                end else begin
                    ack_d = ack_q | hs;
                end
            end
        endcase
        if (push) wr_d = ptr_inc(wr_q);
        // the new head is only presented once the pointers have settled
        state_d = (wr_d == rd_d) ? IDLE : BCAST;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ack_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            vl_q    <= '0;
            vtype_q <= VtypeRst;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            if (push) begin
                vl_q    <= vl_new;
                vtype_q <= vtype_new;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_vl_q[wr_q[AddrW-1:0]]    <= split;
            mem_vtype_q[wr_q[AddrW-1:0]] <= vtype_new;
        end
    end

`ifdef GLOBAL_CFG_DISP_PERF_EN
    logic [31:0] vset_cnt_q, stall_cnt_q, vill_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vset_cnt_q  <= '0;
            stall_cnt_q <= '0;
            vill_cnt_q  <= '0;
        end else begin
            if (push) vset_cnt_q <= vset_cnt_q + 32'd1;
            if (req_valid && !acc_ready_o) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (push && new_vill) vill_cnt_q <= vill_cnt_q + 32'd1;
        end
    end

    assign vset_cnt_o  = vset_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
    assign vill_cnt_o  = vill_cnt_q;
`endif

endmodule

// File: tb/tb_global_cfg_dispatcher.sv
// Directed bench for global_cfg_dispatcher: NrClusters=4, CfgDepth=2, VLENB=128, ELENB=8.
module tb_global_cfg_dispatcher;

    logic         clk;
    logic         rst;
    logic [160:0] acc_req;
    logic         acc_ready;
    logic [12:0]  vl;
    logic [8:0]   vtype;
    logic [3:0]   cl_valid;
    logic [3:0]   cl_ready;
    logic [43:0]  cl_vl;
    logic [8:0]   cl_vtype;

    int total = 0;
    int bad   = 0;

    global_cfg_dispatcher dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .acc_req_i      (acc_req),
        .acc_ready_o    (acc_ready),
        .vl_o           (vl),
        .vtype_o        (vtype),
        .cl_cfg_valid_o (cl_valid),
        .cl_cfg_ready_i (cl_ready),
        .cl_vl_o        (cl_vl),
        .cl_vtype_o     (cl_vtype)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] vsetvli(input logic [4:0] rd, input logic [4:0] rs1,
                                            input logic [10:0] zimm);
        return {1'b0, zimm, rs1, 3'b111, rd, 7'h57};
    endfunction

    function automatic logic [31:0] vsetivli(input logic [4:0] rd, input logic [4:0] uimm,
                                             input logic [9:0] zimm);
        return {2'b11, zimm, uimm, 3'b111, rd, 7'h57};
    endfunction

    function automatic logic [31:0] vsetvl(input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [4:0] rs2);
        return {7'b1000000, rs2, rs1, 3'b111, rd, 7'h57};
    endfunction

    function automatic logic [43:0] cv(input logic [10:0] a0, input logic [10:0] a1,
                                       input logic [10:0] a2, input logic [10:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    task automatic req(input logic v, input logic [31:0] insn,
                       input logic [63:0] rs1, input logic [63:0] rs2);
        acc_req = {v, insn, rs1, rs2};
    endtask

    task automatic idle();
        acc_req = '0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst      = 1'b1;
        acc_req  = '0;
        cl_ready = 4'h0;
        repeat (2) @(negedge clk);
        chk("rst_vl", 64'(vl), 64'd0);
        chk("rst_vtype", 64'(vtype), 64'h100);
        chk("rst_valid", 64'(cl_valid), 64'h0);
        chk("rst_clvl", 64'(cl_vl), 64'h0);
        chk("rst_clvtype", 64'(cl_vtype), 64'h100);
        chk("rst_ready", 64'(acc_ready), 64'd1);
        rst = 1'b0;

        // e8 m1, rs1=37
        req(1'b1, vsetvli(5'd1, 5'd2, 11'h000), 64'd37, 64'd0);
        @(negedge clk);
        idle();
        chk("t1_vl", 64'(vl), 64'd37);
        chk("t1_vtype", 64'(vtype), 64'h000);
        chk("t1_valid", 64'(cl_valid), 64'hf);
        chk("t1_clvl", 64'(cl_vl), 64'(cv(10, 9, 9, 9)));
        chk("t1_clvtype", 64'(cl_vtype), 64'h000);
        cl_ready = 4'hf;
        @(negedge clk);
        chk("t1_popped", 64'(cl_valid), 64'h0);

        // non-OPCFG is accepted and ignored
        req(1'b1, 32'h0000_0033, 64'd5, 64'd0);
        @(negedge clk);
        idle();
        chk("nop_vl", 64'(vl), 64'd37);
        chk("nop_valid", 64'(cl_valid), 64'h0);

        // e32 m2, rs1=x0, rd=x1 -> VLMAX
        req(1'b1, vsetvli(5'd1, 5'd0, 11'h011), 64'd0, 64'd0);
        @(negedge clk);
        idle();
        chk("t2_vl", 64'(vl), 64'd256);
        chk("t2_vtype", 64'(vtype), 64'h011);
        chk("t2_valid", 64'(cl_valid), 64'hf);
        chk("t2_clvl", 64'(cl_vl), 64'(cv(64, 64, 64, 64)));
        @(negedge clk);

        // vsetvl e64 mf8 -> vill
        req(1'b1, vsetvl(5'd1, 5'd2, 5'd3), 64'd10, 64'h1d);
        @(negedge clk);
        idle();
        chk("t3_vtype", 64'(vtype), 64'h100);
        chk("t3_vl", 64'(vl), 64'd0);
        chk("t3_clvtype", 64'(cl_vtype), 64'h100);
        chk("t3_clvl", 64'(cl_vl), 64'h0);
        chk("t3_valid", 64'(cl_valid), 64'hf);
        @(negedge clk);

        // e8 m8, huge rs1 -> clamp
        req(1'b1, vsetvli(5'd1, 5'd2, 11'h003), 64'h1_0000_0000, 64'd0);
        @(negedge clk);
        idle();
        chk("t4_vl", 64'(vl), 64'd4096);
        chk("t4_clvl", 64'(cl_vl), 64'(cv(1024, 1024, 1024, 1024)));
        @(negedge clk);

        // vsetivli uimm=31, uneven split
        req(1'b1, vsetivli(5'd1, 5'd31, 10'h000), 64'd0, 64'd0);
        @(negedge clk);
        idle();
        chk("ivli_vl", 64'(vl), 64'd31);
        chk("ivli_clvl", 64'(cl_vl), 64'(cv(8, 8, 8, 7)));
        @(negedge clk);

        // rd=x0, rs1=x0 keeps vl
        req(1'b1, vsetvli(5'd0, 5'd0, 11'h008), 64'd0, 64'd0);
        @(negedge clk);
        idle();
        chk("keep_vl", 64'(vl), 64'd31);
        chk("keep_vtype", 64'(vtype), 64'h008);
        chk("keep_clvl", 64'(cl_vl), 64'(cv(8, 8, 8, 7)));
        @(negedge clk);

        // FIFO fill with cluster 2 stalled
        cl_ready = 4'b1011;
        req(1'b1, vsetivli(5'd1, 5'd5, 10'h000), 64'd0, 64'd0);
        chk("ff_ready0", 64'(acc_ready), 64'd1);
        @(negedge clk);
        req(1'b1, vsetivli(5'd1, 5'd6, 10'h000), 64'd0, 64'd0);
        chk("ff_validA", 64'(cl_valid), 64'hf);
        chk("ff_ready1", 64'(acc_ready), 64'd1);
        chk("ff_clvlA", 64'(cl_vl), 64'(cv(2, 1, 1, 1)));
        @(negedge clk);
        req(1'b1, vsetivli(5'd1, 5'd7, 10'h000), 64'd0, 64'd0);
        chk("ff_full", 64'(acc_ready), 64'd0);
        chk("ff_valid2", 64'(cl_valid), 64'h4);
        chk("ff_vlB", 64'(vl), 64'd6);
        @(negedge clk);
        chk("ff_hold", 64'(acc_ready), 64'd0);
        chk("ff_valid2b", 64'(cl_valid), 64'h4);
        chk("ff_vlheld", 64'(vl), 64'd6);
        chk("ff_clvlA2", 64'(cl_vl), 64'(cv(2, 1, 1, 1)));
        cl_ready = 4'hf;
        @(negedge clk);
        chk("ff_freed", 64'(acc_ready), 64'd1);
        chk("ff_validB", 64'(cl_valid), 64'hf);
        chk("ff_clvlB", 64'(cl_vl), 64'(cv(2, 2, 1, 1)));
        chk("ff_vlB2", 64'(vl), 64'd6);
        @(negedge clk);
        idle();
        chk("ff_vlC", 64'(vl), 64'd7);
        chk("ff_validC", 64'(cl_valid), 64'hf);
        chk("ff_clvlC", 64'(cl_vl), 64'(cv(2, 2, 2, 1)));
        @(negedge clk);
        chk("ff_drain", 64'(cl_valid), 64'h0);
        chk("ff_readyend", 64'(acc_ready), 64'd1);

        // reset mid-broadcast
        cl_ready = 4'h0;
        req(1'b1, vsetivli(5'd1, 5'd9, 10'h000), 64'd0, 64'd0);
        @(negedge clk);
        idle();
        chk("mr_valid", 64'(cl_valid), 64'hf);
        cl_ready = 4'b0001;
        @(negedge clk);
        chk("mr_partial", 64'(cl_valid), 64'he);
        cl_ready = 4'h0;
        rst = 1'b1;
        @(negedge clk);
        chk("mr_valid0", 64'(cl_valid), 64'h0);
        chk("mr_vl", 64'(vl), 64'd0);
        chk("mr_vtype", 64'(vtype), 64'h100);
        chk("mr_ready", 64'(acc_ready), 64'd1);
        chk("mr_clvl", 64'(cl_vl), 64'h0);
        chk("mr_clvtype", 64'(cl_vtype), 64'h100);
        rst = 1'b0;
        @(negedge clk);
        chk("mr_after", 64'(cl_valid), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
